// File: rtl/uart_hamming_pkg.sv
// ============================================================================
// uart_hamming_pkg : shared FSM encoding, codeword bit map, Hamming(7,4) helpers
// Revision: 1.0
// ============================================================================
`default_nettype none

package uart_hamming_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYND = 2'd1,
    FIX  = 2'd2,
    PUSH = 2'd3
  } state_e;

  // Codeword bit indices; Hamming position n lives at bit n-1.
  localparam int unsigned P1 = 0;
  localparam int unsigned P2 = 1;
  localparam int unsigned D1 = 2;
  localparam int unsigned P4 = 3;
  localparam int unsigned D2 = 4;
  localparam int unsigned D3 = 5;
  localparam int unsigned D4 = 6;

  function automatic logic [2:0] syndrome(input logic [6:0] cw);
    logic s1, s2, s4;
    s1 = cw[P1] ^ cw[D1] ^ cw[D2] ^ cw[D4];
    s2 = cw[P2] ^ cw[D1] ^ cw[D3] ^ cw[D4];
    s4 = cw[P4] ^ cw[D2] ^ cw[D3] ^ cw[D4];
    return {s4, s2, s1};
  endfunction

  // d = {d4,d3,d2,d1}
  function automatic logic [6:0] encode(input logic [3:0] d);
    logic [6:0] cw;
    cw     = '0;
    cw[D1] = d[0];
    cw[D2] = d[1];
    cw[D3] = d[2];
    cw[D4] = d[3];
    cw[P1] = d[0] ^ d[1] ^ d[3];
    cw[P2] = d[0] ^ d[2] ^ d[3];
    cw[P4] = d[1] ^ d[2] ^ d[3];
    return cw;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_nibble_fifo.sv
// ============================================================================
// uart_nibble_fifo : small synchronous FIFO holding {corr, nibble} entries
// Revision: 1.0
// ============================================================================
`default_nettype none

module uart_nibble_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] C_FULL = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             w_pop_ok, w_push_ok;

  assign empty_o   = (count_q == '0);
  assign full_o    = (count_q == C_FULL);
  // A push into a full queue is legal when the head leaves in the same cycle.
  assign w_pop_ok  = pop_i & ~empty_o;
  assign w_push_ok = push_i & (~full_o | w_pop_ok);
  assign rdata_o   = empty_o ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    if (w_push_ok & ~w_pop_ok) count_d = count_q + 1'b1;
    else if (~w_push_ok & w_pop_ok) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (w_pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

`default_nettype wire

// File: rtl/uart_hamming_decoder.sv
// ============================================================================
// uart_hamming_decoder : Hamming(7,4) single-error correcting decoder + FIFO.
// Statistics counters built only when UART_HAMMING_STATS_EN is defined.
// Revision: 1.0
// ============================================================================
`default_nettype none

module uart_hamming_decoder
  import uart_hamming_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic [6:0]       cw_in,
  input  logic             cw_valid,
  output logic [3:0]       out_data,
  output logic             out_corr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic [CNT_W-1:0] corr_cnt,
  output logic [CNT_W-1:0] drop_cnt
);

  state_e     state_q;
  logic [6:0] cw_q;
  logic [2:0] synd_q;
  logic [3:0] nib_q;
  logic       corr_q;
  logic       vld_prev_q;

  logic       w_edge;
  logic       w_pop;
  logic       w_push;
  logic       w_push_drop;
  logic       w_wr;
  logic       w_full;
  logic       w_empty;
  logic [6:0] w_flip;
  logic [6:0] w_fixed;
  logic [4:0] w_rdata;

  assign w_edge      = ena & cw_valid & ~vld_prev_q;
  assign w_pop       = out_valid & out_ready;
  assign w_push      = ena & (state_q == PUSH);
  assign w_push_drop = w_push & w_full & ~w_pop;
  assign w_wr        = w_push & ~w_push_drop;

  always_comb begin
    w_flip = '0;
    if (synd_q != 3'd0) w_flip[synd_q - 3'd1] = 1'b1;
  end
  assign w_fixed = cw_q ^ w_flip;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cw_q       <= '0;
      synd_q     <= '0;
      nib_q      <= '0;
      corr_q     <= 1'b0;
      vld_prev_q <= 1'b0;
    end else if (ena) begin
      vld_prev_q <= cw_valid;
      case (state_q)
        IDLE: begin
          if (w_edge) begin
            cw_q    <= cw_in;
            state_q <= SYND;
          end
        end
        SYND: begin
          synd_q  <= syndrome(cw_q);
          state_q <= FIX;
        end
        FIX: begin
          nib_q   <= {w_fixed[D4], w_fixed[D3], w_fixed[D2], w_fixed[D1]};
          corr_q  <= (synd_q != 3'd0);
          state_q <= PUSH;
        end
        PUSH: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  uart_nibble_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (5)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (w_wr),
    .pop_i   (w_pop),
    .wdata_i ({corr_q, nib_q}),
    .rdata_o (w_rdata),
    .full_o  (w_full),
    .empty_o (w_empty)
  );

  assign out_valid = ~w_empty;
  assign out_corr  = w_rdata[4];
  assign out_data  = w_rdata[3:0];
  assign busy      = (state_q != IDLE);

`ifdef UART_HAMMING_STATS_EN
  logic [CNT_W-1:0] corr_cnt_q, corr_cnt_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic             w_corr_inc;
  logic             w_edge_drop;
  logic [1:0]       w_drop_inc;

  // Widen by one bit so a carry out means the counter would wrap.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                input logic [1:0]       inc);
    logic [CNT_W:0] sum;
    sum = {1'b0, a} + {{(CNT_W-1){1'b0}}, inc};
    return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
  endfunction

  assign w_corr_inc  = ena & (state_q == FIX) & (synd_q != 3'd0);
  assign w_edge_drop = w_edge & (state_q != IDLE);
  assign w_drop_inc  = {1'b0, w_edge_drop} + {1'b0, w_push_drop};
  assign corr_cnt_d  = sat_add(corr_cnt_q, {1'b0, w_corr_inc});
  assign drop_cnt_d  = sat_add(drop_cnt_q, w_drop_inc);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      corr_cnt_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      corr_cnt_q <= corr_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign corr_cnt = corr_cnt_q;
  assign drop_cnt = drop_cnt_q;
`else
  assign corr_cnt = '0;
  assign drop_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: doc/uart_hamming_decoder.md
Name: uart_hamming_decoder

Overview:
- Sits directly downstream of the UART receiver.
- Takes each 7-bit Hamming(7,4) codeword, corrects any single-bit error, and queues the 4-bit payload in a small FIFO with a ready/valid output.
- Keeps saturating correction and drop statistics for debug readout.

Parameters:
- DEPTH, 4, FIFO entries (power of two, 2..16).
- CNT_W, 8, width of the statistics counters.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- ena  in  1  enable; when low, FSM and input edge detector hold; FIFO pop still honoured
- cw_in  in  7  codeword; bit0 received first (Hamming position 1)
- cw_valid  in  1  receiver valid level; a rising edge marks a new codeword
- out_data  out  4  decoded nibble {d4,d3,d2,d1}
- out_corr  out  1  head entry was corrected
- out_valid  out  1  FIFO not empty
- out_ready  in  1  consumer accepts head when out_valid & out_ready
- busy  out  1  FSM not in IDLE
- corr_cnt  out  CNT_W  corrected codewords, saturating
- drop_cnt  out  CNT_W  dropped codewords, saturating

Behaviour:
- Reset: clk is the only clock; rst is asynchronous and active-high. On reset, all outputs are 0, the FIFO is empty, the FSM is in IDLE, and the cw_valid history register is 0. Reset mid-decode discards the in-flight word without counting it.
- Edge detect: a new word arrives when ena=1, cw_valid=1 and the registered previous cw_valid=0. The history register updates only when ena=1.
- Bit map: p1=cw[0], p2=cw[1], d1=cw[2], p4=cw[3], d2=cw[4], d3=cw[5], d4=cw[6].
- Syndrome: s1=cw0^cw2^cw4^cw6, s2=cw1^cw2^cw5^cw6, s4=cw3^cw4^cw5^cw6, s={s4,s2,s1}. A nonzero s flips bit s-1.
- FSM (advances only when ena=1):
  - IDLE: on edge, capture cw_in and go to SYND.
  - SYND: register the syndrome; go to FIX.
  - FIX: apply the correction and extract the nibble; set corr flag = (s!=0); if s!=0, corr_cnt+1; go to PUSH.
  - PUSH: write {corr,nibble} to the FIFO; if full, drop_cnt+1 and do not write. Return to IDLE.
- Latency: edge sampled at cycle N → FIFO write at N+3 → out_valid high at N+4 when the FIFO was empty.
- Edge while busy: the word is dropped, drop_cnt+1, and the FSM is unaffected.
- Pop: on out_valid & out_ready, advance the read pointer. out_data/out_corr always present the head entry and are 0 when empty.
- Simultaneous push and pop when full: both occur, no drop, count stays DEPTH.
- Pop when empty: ignored.
- Pointers wrap modulo DEPTH. Full/empty use a count register of width log2(DEPTH)+1.
- Counters: saturate at all-ones and never wrap. An edge-drop and a PUSH-drop in the same cycle add 2, saturating.
- Behaviour is undefined for double-bit errors: they are miscorrected as single errors; no detection is required.

Optional Feature:
- Macro: UART_HAMMING_STATS_EN.
- Defined: corr_cnt and drop_cnt counters are implemented as above.
- Undefined: counters are not synthesised and corr_cnt and drop_cnt are tied to 0. Ports remain, and all other behaviour is identical.

Decomposition:
- Shared package uart_hamming_pkg:
  - FSM state encoding (IDLE=0, SYND=1, FIX=2, PUSH=3).
  - Codeword bit-position constants (P1..D4 indices).
  - A syndrome function and a 4-bit encode function for shared use with the transmitter-side encoder and testbench.
- Sub-module uart_nibble_fifo (parameterised DEPTH, width 5) holds the queue. The decoder FSM and counters stay in the top module.

Test Plan:
- Clean word: cw_in=7'h55, cw_valid rises → out_data=4'b1011, out_corr=0, out_valid at edge+4; corr_cnt=0.
- Single error: cw_in=7'h45 (bit4 flipped) → s=5, out_data=4'b1011, out_corr=1, corr_cnt=1.
- All 7 single-bit flips of 7'h55, then 7'h00 and 7'h7F: every word decodes to the expected nibble; corr_cnt=7 (with UART_HAMMING_STATS_EN).
- Overflow: out_ready=0, send 5 clean words spaced 6 cycles apart (DEPTH=4) → 4 queued, drop_cnt=1. Raise out_ready → 4 nibbles delivered in order, then out_valid=0.
- Busy drop and level-hold: toggle cw_valid 0→1 twice within 3 cycles → second word dropped, drop_cnt=1. Holding cw_valid high for 20 cycles gives no extra captures.
- Reset mid-operation: assert rst in FIX with 2 entries queued → next cycle out_valid=0, busy=0, counters 0. The decoder then accepts 7'h55 normally.
